// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// inst_fetch_unit_if : imem request/response, redirect and decode channels
// Revision 1.0
// ============================================================================
interface inst_fetch_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic            out_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  redirect_valid, redirect_pc,
        output out_valid, out_inst, out_pc, out_fault,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output redirect_valid, redirect_pc,
        input  out_valid, out_inst, out_pc, out_fault,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// inst_fetch_unit : fetch PC, single-outstanding imem requests, instruction FIFO
// Revision 1.0
// ============================================================================
module inst_fetch_unit #(
    parameter int          XLEN      = 64,
    parameter logic [63:0] RESET_PC  = 64'h8000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_unit_if.master ifu_io
);
    localparam int              AW      = $clog2(BUF_DEPTH);
    localparam logic [31:0]     c_nop   = 32'h0000_0013;
    localparam logic [AW:0]     c_depth = BUF_DEPTH[AW:0];
    localparam logic [XLEN-1:0] c_step  = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            req_valid_q;

    logic [XLEN-1:0] buf_pc_q    [BUF_DEPTH];
    logic [31:0]     buf_inst_q  [BUF_DEPTH];
    logic            buf_fault_q [BUF_DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [XLEN-1:0] last_pc_q;
    logic [31:0]     last_inst_q;
    logic            last_fault_q;

    logic            w_redirect;
    logic            w_misalign;
    logic            w_req_fire;
    logic            w_rsp;
    logic [AW:0]     w_count;
    logic [AW:0]     w_count_nxt;
    logic            w_credit;
    logic            w_out_valid;
    logic            w_pop;
    logic [AW-1:0]   w_rd_idx;
    logic [AW-1:0]   w_wr_idx;
    logic            w_push;
    logic [XLEN-1:0] w_push_pc;
    logic [31:0]     w_push_inst;
    logic            w_push_fault;
    state_t          w_redir_state;

    assign w_redirect  = ifu_io.redirect_valid;
    assign w_misalign  = |ifu_io.redirect_pc[1:0];
    assign w_req_fire  = req_valid_q && ifu_io.imem_req_ready;
    assign w_rsp       = ifu_io.imem_rsp_valid;
    assign w_count     = wr_ptr_q - rd_ptr_q;
    assign w_out_valid = (w_count != '0);
    assign w_pop       = w_out_valid && ifu_io.out_ready;
    assign w_rd_idx    = rd_ptr_q[AW-1:0];
    assign w_wr_idx    = wr_ptr_q[AW-1:0];

    // A misaligned redirect shares the push path so it lands in the freshly flushed buffer.
    always_comb begin
        w_push       = 1'b0;
        w_push_pc    = req_pc_q;
        w_push_inst  = ifu_io.imem_rsp_data;
        w_push_fault = ifu_io.imem_rsp_err;
        if (w_redirect) begin
            if (w_misalign) begin
                w_push       = 1'b1;
                w_push_pc    = ifu_io.redirect_pc;
                w_push_inst  = c_nop;
                w_push_fault = 1'b1;
            end
        end else if (state_q == S_WAIT && w_rsp) begin
            w_push = 1'b1;
            if (ifu_io.imem_rsp_err) begin
                w_push_inst = c_nop;
            end
        end
    end

    always_comb begin
        if (w_redirect) begin
            w_count_nxt = {{AW{1'b0}}, w_push};
        end else begin
            w_count_nxt = w_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    assign w_credit = (w_count_nxt < c_depth);

    always_comb begin
        w_redir_state = S_FETCH;
        if (w_misalign) begin
            w_redir_state = S_HALT;
        end else begin
            case (state_q)
                S_WAIT:  w_redir_state = w_rsp ? S_FETCH : S_DRAIN;
                S_FETCH: w_redir_state = w_req_fire ? S_DRAIN : S_FETCH;
                S_DRAIN: w_redir_state = w_rsp ? S_FETCH : S_DRAIN;
                default: w_redir_state = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            fetch_pc_q  <= RESET_PC[XLEN-1:0];
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else if (w_redirect) begin
            fetch_pc_q  <= ifu_io.redirect_pc;
            state_q     <= w_redir_state;
            req_valid_q <= (w_redir_state == S_FETCH) && w_credit;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (w_req_fire) begin
                        req_pc_q    <= fetch_pc_q;
                        fetch_pc_q  <= fetch_pc_q + c_step;
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end else begin
                        req_valid_q <= w_credit;
                    end
                end
                S_WAIT: begin
                    if (w_rsp) begin
                        state_q     <= ifu_io.imem_rsp_err ? S_HALT : S_FETCH;
                        req_valid_q <= !ifu_io.imem_rsp_err && w_credit;
                    end
                end
                S_DRAIN: begin
                    if (w_rsp) begin
                        state_q     <= S_FETCH;
                        req_valid_q <= w_credit;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_pc_q    <= '0;
            last_inst_q  <= '0;
            last_fault_q <= 1'b0;
        end else begin
            if (w_out_valid) begin
                last_pc_q    <= buf_pc_q[w_rd_idx];
                last_inst_q  <= buf_inst_q[w_rd_idx];
                last_fault_q <= buf_fault_q[w_rd_idx];
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_redirect) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            buf_pc_q[w_wr_idx]    <= w_push_pc;
            buf_inst_q[w_wr_idx]  <= w_push_inst;
            buf_fault_q[w_wr_idx] <= w_push_fault;
        end
    end

    assign ifu_io.imem_req_valid = req_valid_q;
    assign ifu_io.imem_req_addr  = fetch_pc_q;
    assign ifu_io.out_valid      = w_out_valid;
    assign ifu_io.out_inst       = w_out_valid ? buf_inst_q[w_rd_idx]  : last_inst_q;
    assign ifu_io.out_pc         = w_out_valid ? buf_pc_q[w_rd_idx]    : last_pc_q;
    assign ifu_io.out_fault      = w_out_valid ? buf_fault_q[w_rd_idx] : last_fault_q;
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// tb_inst_fetch_unit : directed checks of fetch sequencing, back-pressure,
// redirects, fetch faults and reset.
module tb_inst_fetch_unit;
    localparam int          XLEN = 64;
    localparam logic [63:0] RPC  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_unit_if #(.XLEN(XLEN)) bus ();

    inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .BUF_DEPTH(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ifu_io (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 1;
    int first_hs = -1;
    int first_out = -1;
    logic [63:0] stale_addr = '1;
    logic [63:0] err_addr = '1;
    logic [63:0] req_log [$];
    logic [63:0] pend_addr [$];
    int          pend_due [$];
    logic [63:0] o_pc [$];
    logic [31:0] o_inst [$];
    logic        o_flt [$];

    function automatic logic [31:0] mw(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [63:0] qpc(input int i);
        if (i < o_pc.size()) return o_pc[i];
        return '1;
    endfunction

    function automatic logic [63:0] qinst(input int i);
        if (i < o_inst.size()) return {32'h0, o_inst[i]};
        return '1;
    endfunction

    function automatic logic [63:0] qflt(input int i);
        if (i < o_flt.size()) return {63'h0, o_flt[i]};
        return '1;
    endfunction

    function automatic logic [63:0] qreq(input int i);
        if (i < req_log.size()) return req_log[i];
        return '1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        o_pc.delete();
        o_inst.delete();
        o_flt.delete();
        first_hs  = -1;
        first_out = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        clear_logs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_out(input int n, input string tag);
        int k = 0;
        while (o_pc.size() < n && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 64'(o_pc.size() >= n), 64'd1);
    endtask

    task automatic wait_req(input int n, input string tag);
        int k = 0;
        while (req_log.size() < n && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 64'(req_log.size() >= n), 64'd1);
    endtask

    task automatic redirect(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    // Handshake and delivery monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            req_log.push_back(bus.imem_req_addr);
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + lat);
            if (first_hs < 0) first_hs = cyc;
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            o_pc.push_back(bus.out_pc);
            o_inst.push_back(bus.out_inst);
            o_flt.push_back(bus.out_fault);
            if (first_out < 0) first_out = cyc;
        end
    end

    // In-order memory responder with programmable latency.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = (pend_addr[0] == stale_addr) ? 32'hDEAD_BEEF : mw(pend_addr[0]);
            bus.imem_rsp_err   = (pend_addr[0] == err_addr);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;

        // Reset state, then streaming fetch with 1-cycle memory
        tick();
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_fault", 64'(bus.out_fault), 64'd0);
        tick();
        rst_n = 1'b1;
        wait_out(4, "t1_wait");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_req%0d", i), qreq(i), RPC + 64'(4 * i));
            chk($sformatf("t1_pc%0d", i), qpc(i), RPC + 64'(4 * i));
            chk($sformatf("t1_inst%0d", i), qinst(i), {32'h0, mw(RPC + 64'(4 * i))});
        end
        chk("t1_flt0", qflt(0), 64'd0);
        chk("t1_latency", 64'(first_out - first_hs), 64'd2);

        // Decode stalled: buffer fills to depth, requests stop
        bus.out_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        @(negedge clk);
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_req_cnt", 64'(req_log.size()), 64'd2);
        chk("t2_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("t2_addr", bus.imem_req_addr, 64'h8000_0008);
        chk("t2_head_pc", bus.out_pc, 64'h8000_0000);
        chk("t2_none_out", 64'(o_pc.size()), 64'd0);
        tick();
        bus.out_ready = 1'b1;
        wait_out(4, "t2_wait");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_pc%0d", i), qpc(i), RPC + 64'(4 * i));
        end

        // Redirect with a request outstanding (slow memory)
        lat = 3;
        stale_addr = RPC;
        do_reset();
        wait_req(1, "t3_wait_req");
        redirect(64'h8000_1000);
        @(negedge clk);
        chk("t3_flushed", 64'(bus.out_valid), 64'd0);
        chk("t3_drain_noreq", 64'(bus.imem_req_valid), 64'd0);
        wait_out(1, "t3_wait_out");
        chk("t3_pc0", qpc(0), 64'h8000_1000);
        chk("t3_inst0", qinst(0), {32'h0, mw(64'h8000_1000)});
        chk("t3_req1", qreq(1), 64'h8000_1000);
        lat = 1;

        // Redirect coincident with rsp_valid
        do_reset();
        wait_req(1, "t4a_wait_req");
        redirect(64'h8000_2000);
        wait_out(1, "t4a_wait_out");
        chk("t4a_pc0", qpc(0), 64'h8000_2000);
        chk("t4a_inst0", qinst(0), {32'h0, mw(64'h8000_2000)});
        chk("t4a_req1", qreq(1), 64'h8000_2000);

        // Redirect coincident with request handshake
        bus.imem_req_ready = 1'b0;
        do_reset();
        begin
            int k = 0;
            while (!bus.imem_req_valid && k < 20) begin
                tick();
                k++;
            end
        end
        chk("t4b_req_pending", 64'(bus.imem_req_valid), 64'd1);
        bus.imem_req_ready = 1'b1;
        redirect(64'h8000_3000);
        wait_out(1, "t4b_wait_out");
        chk("t4b_req0", qreq(0), RPC);
        chk("t4b_pc0", qpc(0), 64'h8000_3000);
        chk("t4b_req1", qreq(1), 64'h8000_3000);
        stale_addr = '1;

        // Fetch fault halts fetch until a redirect
        err_addr = 64'h8000_0008;
        do_reset();
        wait_out(3, "t5_wait_out");
        chk("t5_flt1", qflt(1), 64'd0);
        chk("t5_pc2", qpc(2), 64'h8000_0008);
        chk("t5_inst2", qinst(2), 64'h13);
        chk("t5_flt2", qflt(2), 64'd1);
        repeat (10) tick();
        @(negedge clk);
        chk("t5_halt_reqs", 64'(req_log.size()), 64'd3);
        chk("t5_halt_valid", 64'(bus.imem_req_valid), 64'd0);
        tick();
        redirect(64'h8000_0100);
        wait_out(4, "t5_wait_resume");
        chk("t5_req3", qreq(3), 64'h8000_0100);
        chk("t5_pc3", qpc(3), 64'h8000_0100);
        chk("t5_flt3", qflt(3), 64'd0);
        err_addr = '1;

        // Misaligned redirect: single fault entry, no memory traffic
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
        do_reset();
        repeat (3) tick();
        redirect(64'h8000_0102);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        chk("t6_valid", 64'(bus.out_valid), 64'd1);
        chk("t6_pc", bus.out_pc, 64'h8000_0102);
        chk("t6_inst", 64'(bus.out_inst), 64'h13);
        chk("t6_fault", 64'(bus.out_fault), 64'd1);
        chk("t6_noreq", 64'(bus.imem_req_valid), 64'd0);
        repeat (5) tick();
        chk("t6_reqcnt", 64'(req_log.size()), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("t6_outcnt", 64'(o_pc.size()), 64'd1);
        chk("t6_empty", 64'(bus.out_valid), 64'd0);
        chk("t6_hold_pc", bus.out_pc, 64'h8000_0102);

        // Reset asserted while a request is outstanding
        lat = 3;
        do_reset();
        redirect(64'h8000_4000);
        wait_req(1, "t7_wait_req");
        chk("t7_req0", qreq(0), 64'h8000_4000);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t7_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t7_rst_req", 64'(bus.imem_req_valid), 64'd0);
        chk("t7_rst_pc", bus.out_pc, 64'd0);
        chk("t7_rst_inst", 64'(bus.out_inst), 64'd0);
        tick();
        clear_logs();
        tick();
        lat = 1;
        rst_n = 1'b1;
        wait_req(1, "t7_wait_req2");
        chk("t7_first_req", qreq(0), RPC);
        wait_out(1, "t7_wait_out");
        chk("t7_first_pc", qpc(0), RPC);
        chk("t7_first_inst", qinst(0), {32'h0, mw(RPC)});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
